// File: rtl/lives_led_indicator.sv
// Wrong-hit tracker and LED bar driver: thermometer bar during play, a fixed
// number of full-bar flashes on the last allowed mistake, then steady game over.
module lives_led_indicator #(
    parameter int N_LED     = 4,
    parameter int MAX_WRONG = 3,
    parameter int CNT_W     = 3,
    parameter int BLINK_DIV = 25000000,
    parameter int BLINK_N   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             wrong,
    output logic [CNT_W-1:0] wrong_time,
    output logic             game_over,
    output logic [N_LED-1:0] LED
);

    localparam int DIV_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * BLINK_N);

    localparam logic [CNT_W-1:0]  LAST_HIT = CNT_W'(MAX_WRONG - 1);
    localparam logic [CNT_W-1:0]  MAX_HIT  = CNT_W'(MAX_WRONG);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
    localparam logic [DIV_W-1:0]  CYC_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [DIV_W-1:0]  CYC_ONE  = DIV_W'(32'd1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * BLINK_N - 1);
    localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(32'd1);
    localparam logic [N_LED-1:0]  LED_ON    = {N_LED{1'b1}};
    localparam logic [N_LED-1:0]  LED_OFF   = {N_LED{1'b0}};

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_FLASH = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   wrong_time_r, wrong_time_s;
    logic               game_over_r, game_over_s;
    logic [N_LED-1:0]   led_r, led_s;
    logic [DIV_W-1:0]   cyc_r, cyc_s;
    logic [HALF_W-1:0]  half_r, half_s;

    // Bar with one lit LED per mistake; saturates to all-on past N_LED.
    function automatic logic [N_LED-1:0] thermo(input logic [CNT_W-1:0] cnt);
        logic [N_LED-1:0] bar;
        bar = LED_OFF;
        for (int i = 0; i < N_LED; i++) begin
            if (int'(cnt) > i) begin
                bar[i] = 1'b1;
            end else begin
                bar[i] = 1'b0;
            end
        end
        return bar;
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_PLAY;
            wrong_time_r <= {CNT_W{1'b0}};
            game_over_r  <= 1'b0;
            led_r        <= LED_OFF;
            cyc_r        <= {DIV_W{1'b0}};
            half_r       <= {HALF_W{1'b0}};
        end else begin
            state_r      <= state_s;
            wrong_time_r <= wrong_time_s;
            game_over_r  <= game_over_s;
            led_r        <= led_s;
            cyc_r        <= cyc_s;
            half_r       <= half_s;
        end
    end

    // Next-state and next-output logic; restart overrides any wrong pulse.
    always_comb begin
        state_s      = state_r;
        wrong_time_s = wrong_time_r;
        game_over_s  = game_over_r;
        led_s        = led_r;
        cyc_s        = cyc_r;
        half_s       = half_r;

        if (restart) begin
            state_s      = ST_PLAY;
            wrong_time_s = {CNT_W{1'b0}};
            game_over_s  = 1'b0;
            led_s        = LED_OFF;
            cyc_s        = {DIV_W{1'b0}};
            half_s       = {HALF_W{1'b0}};
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (wrong && (wrong_time_r == LAST_HIT)) begin
                        state_s      = ST_FLASH;
                        wrong_time_s = MAX_HIT;
                        game_over_s  = 1'b1;
                        led_s        = LED_ON;
                        cyc_s        = {DIV_W{1'b0}};
                        half_s       = {HALF_W{1'b0}};
                    end else if (wrong) begin
                        wrong_time_s = wrong_time_r + CNT_ONE;
                        led_s        = thermo(wrong_time_r + CNT_ONE);
                    end else begin
                        led_s = thermo(wrong_time_r);
                    end
                end
                ST_FLASH: begin
                    if (cyc_r != CYC_LAST) begin
                        cyc_s = cyc_r + CYC_ONE;
                    end else if (half_r == HALF_LAST) begin
                        state_s = ST_OVER;
                        cyc_s   = {DIV_W{1'b0}};
                        half_s  = {HALF_W{1'b0}};
                        led_s   = LED_ON;
                    end else begin
                        cyc_s  = {DIV_W{1'b0}};
                        half_s = half_r + HALF_ONE;
                        led_s  = ~led_r;
                    end
                end
                ST_OVER: begin
                    led_s       = LED_ON;
                    game_over_s = 1'b1;
                end
                default: begin
                    state_s      = ST_PLAY;
                    wrong_time_s = {CNT_W{1'b0}};
                    game_over_s  = 1'b0;
                    led_s        = LED_OFF;
                    cyc_s        = {DIV_W{1'b0}};
                    half_s       = {HALF_W{1'b0}};
                end
            endcase
        end
    end

    assign wrong_time = wrong_time_r;
    assign game_over  = game_over_r;
    assign LED        = led_r;

endmodule

// File: doc/lives_led_indicator.md
Name: lives_led_indicator

Overview:
- Tracks wrong hits during a game and drives the status LED bar.
- During play, the LEDs show a thermometer bar of the mistakes made so far.
- On the final allowed mistake, the bar flashes a fixed number of times, then holds all-on and flags game over until restart.
- Sits between the hit-judge logic (which produces `wrong` pulses) and the board LED pins. It replaces the combinational fail indicator.

Parameters:
- N_LED, 4: number of LEDs driven.
- MAX_WRONG, 3: wrong hits that end the game (1..2^CNT_W-1).
- CNT_W, 3: width of the wrong-hit counter.
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥1).
- BLINK_N, 3: number of full on/off flash periods before the steady game-over display (≥1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- restart, input, 1: one-cycle pulse that starts a new game.
- wrong, input, 1: one-cycle pulse per wrong hit.
- wrong_time, output, CNT_W: registered count of wrong hits.
- game_over, output, 1: high in FLASH and OVER states.
- LED, output, N_LED: LED drive, 1 = lit.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous, active-high, sampled on the rising edge of clk. All outputs are registered.
- Reset values:
  - state = PLAY
  - wrong_time = 0
  - game_over = 0
  - LED = 0
  - blink cycle counter = 0
  - half-period counter = 0
- Priority: rst > restart > wrong.
- restart in any state:
  - next cycle: PLAY, wrong_time = 0, LED = 0, game_over = 0, blink counters cleared.
- PLAY:
  - On a wrong pulse, wrong_time increments by 1; the result is visible the next cycle.
  - LED[i] = 1 when i < wrong_time, else 0. When wrong_time ≥ N_LED, all LEDs are lit.
  - When wrong arrives with wrong_time == MAX_WRONG-1:
    - next cycle: wrong_time = MAX_WRONG, state = FLASH, game_over = 1, LED = all ones, counters cleared.
    - The thermometer value is not shown for that cycle.
- FLASH:
  - The cycle counter counts 0..BLINK_DIV-1. On its wrap, the half-period counter increments and LED inverts (all ones ↔ all zeros).
  - Half-period k has LED all ones for even k and all zeros for odd k, k = 0..2*BLINK_N-1.
  - When the counter wraps at the end of half-period 2*BLINK_N-1:
    - next cycle: state = OVER, LED = all ones.
  - The FLASH state lasts exactly 2*BLINK_N*BLINK_DIV cycles.
- OVER:
  - LED = all ones steady, game_over = 1.
  - Held until restart or rst.
- wrong pulses in FLASH or OVER are ignored; wrong_time stays at MAX_WRONG and never exceeds it.
- wrong held high for several cycles in PLAY counts once per cycle; each high cycle is a separate hit.
- Simultaneous restart and wrong: restart wins, wrong_time = 0 (the hit is dropped).
- Reset mid-FLASH: state returns to the reset values the next cycle; the flash sequence does not resume.
- The counter width for BLINK_DIV is sized from the parameter. The half-period counter is sized for 2*BLINK_N.

Test Plan (N_LED=4, MAX_WRONG=3, BLINK_DIV=4, BLINK_N=2):
1. rst for 2 cycles, then idle 5 cycles → LED = 0000, wrong_time = 0, game_over = 0 throughout.
2. Two wrong pulses, 3 cycles apart → wrong_time 1 then 2, each one cycle after its pulse. LED = 0001 then 0011. game_over = 0.
3. Third wrong pulse → next cycle: game_over = 1, wrong_time = 3, LED = 1111. LED sequence is 1111×4, 0000×4, 1111×4, 0000×4, then 1111 steady (OVER). Extra wrong pulses leave wrong_time at 3.
4. restart pulse in OVER → next cycle: LED = 0000, wrong_time = 0, game_over = 0. A following wrong pulse gives LED = 0001.
5. With wrong_time = 2, assert restart and wrong in the same cycle → next cycle: wrong_time = 0, game_over = 0, state PLAY.
6. rst asserted 6 cycles into FLASH → next cycle: LED = 0000, game_over = 0, wrong_time = 0. No further toggling.
